apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
- APB requester (initiator) that turns single-beat commands from a local valid/ready command port into APB SETUP/ACCESS transfers.
- Drives psel, penable, paddr, pwrite and pwdata toward one APB slave (8-bit data, 32-bit address).
- Tolerates pready wait states and captures pslverr.
- Bounds each transfer with a wait-state timeout and returns a one-cycle response pulse to the local side.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 8, APB read/write data width.
- TIMEOUT, 16, max ACCESS cycles without pready before abort (must be ≥2).

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- presetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data (ignored on reads).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data (0 for writes/errors).
- rsp_err  out  1  pslverr seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  slave ready.
- pslverr  in  1  slave error, valid when psel&&penable&&pready.

Behaviour:
- Reset value of every output: 0. presetn low clears the FSM to IDLE asynchronously; psel/penable drop immediately, even mid-transfer. No response is issued for an aborted transfer.
- All outputs registered (no combinational path from APB inputs to APB outputs).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; psel=0, penable=0.
  - On cmd_valid, latch cmd_write/cmd_addr/cmd_wdata into paddr/pwrite/pwdata. pwdata=0 on reads.
  - Next state SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, cmd_ready=0. Next state ACCESS unconditionally.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata held stable.
  - Wait counter starts at 0 on entry and increments each cycle pready=0.
  - pready=1: sample pslverr. On reads with pslverr=0, capture prdata into rsp_rdata. Go to RESP.
  - pready=0 and counter==TIMEOUT-1: abort, set rsp_err=1 and rsp_timeout=1, go to RESP. pready arriving in that same cycle wins over timeout.
- RESP (1 cycle):
  - psel=0, penable=0, rsp_valid=1; rsp_err=pslverr (or timeout); rsp_rdata=0 if write or error.
  - Next state IDLE.
  - rsp_* fields hold until the next RESP. rsp_valid is high only in RESP.
- After a transfer, paddr/pwrite keep their last values; pwdata keeps its last value.
- Minimum transfer: cmd accept (IDLE) → SETUP → ACCESS (pready=1) → RESP = 4 cycles. Next accept is 1 cycle later. Throughput is one transfer per 4 cycles at zero wait states.
- No command queueing. cmd_valid while busy is ignored until IDLE (cmd_ready=0).
- pslverr and prdata are ignored in any cycle with pready=0.
- Counter width: clog2(TIMEOUT). It never wraps; it is cleared on SETUP entry.

Decomposition:
- Package apb_pkg:
  - typedef enum apb_state_t {IDLE, SETUP, ACCESS, RESP}
  - localparams APB_ADDR_W=32, APB_DATA_W=8
  - response struct {rdata, err, timeout}
- Sub-module apb_wait_timer (param TIMEOUT; inputs clr, en; output expired).
- The FSM and datapath registers stay in apb_master_ctrl.

Test Plan:
- Write addr 0x5 data 0xA5, pready tied 1 → psel high 2 cycles, penable on 2nd only, paddr=0x5/pwdata=0xA5 stable; rsp_valid pulse 4th cycle, rsp_err=0.
- Read addr 0x3, slave returns 0x3C after 3 wait cycles → penable high 4 cycles, paddr stable; rsp_rdata=0x3C, rsp_err=0, rsp_timeout=0.
- Read addr 0x14 (20), slave asserts pslverr with pready → rsp_err=1, rsp_rdata=0x00, rsp_timeout=0.
- TIMEOUT=4, pready held 0 → abort after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, psel/penable 0 next cycle; cmd_ready returns high. Variant with pready=1 on 4th cycle → normal completion.
- presetn pulsed low during ACCESS → psel/penable 0 within the same cycle, no rsp_valid, cmd_ready=1 after release; next command completes normally.
- Loopback with the team APB slave: write 0x7→0x5A, then read 0x7 → rsp_rdata=0x5A. cmd_valid held high throughout → exactly one accept per transfer.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and widths for the APB requester.
// Covers the state encoding, the default bus widths and the latched response record.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase.
// Counts stalled cycles and flags the last permitted one; it saturates and never wraps.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: turns single-beat valid/ready commands into SETUP/ACCESS transfers.
// Includes a wait-state timeout and returns a one-cycle response pulse per completed transfer.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t state, next_state;
  apb_rsp_t   rsp_q, rsp_next;
  logic       accept;
  logic       expired;

  assign accept = (state == IDLE) && cmd_valid && cmd_ready;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .pclk    (pclk),
    .presetn (presetn),
    .clr     (accept),
    .en      ((state == ACCESS) && !pready),
    .expired (expired)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (pready || expired) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // pready in the last allowed cycle beats the timeout
  always_comb begin
    rsp_next = '0;
    if (pready) begin
      rsp_next.err = pslverr;
      if (!pwrite && !pslverr) rsp_next.rdata = APB_DATA_W'(prdata);
    end else begin
      rsp_next.err     = 1'b1;
      rsp_next.timeout = 1'b1;
    end
  end

  // Handshake and bus controls are flops decoded from next_state so every output is registered.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_q     <= '0;
    end else begin
      state     <= next_state;
      cmd_ready <= (next_state == IDLE);
      psel      <= (next_state == SETUP) || (next_state == ACCESS);
      penable   <= (next_state == ACCESS);
      rsp_valid <= (next_state == RESP);
      if (accept) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_write ? cmd_wdata : '0;
      end
      if ((state == ACCESS) && (next_state == RESP)) begin
        rsp_q <= rsp_next;
      end
    end
  end

  assign rsp_rdata   = DATA_W'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl with a behavioural APB slave and reference memory.
// Directed scenarios are followed by a randomized run of writes, reads, wait states, errors and timeouts.
module tb_apb_master_ctrl;

  localparam int TO = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  pwdata;
  logic [7:0]  prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int checks = 0;
  int errors = 0;
  bit prev_done = 1'b0;

  logic [7:0] slave_mem [16];
  logic [7:0] ref_mem [16];

  apb_master_ctrl #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // One command end to end; the slave inserts `waits` stalled ACCESS cycles before pready.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [7:0] wd,
                      input int waits, input bit serr, input bit hold);
    int n, acc_seen, psel_cnt, pen_cnt, rsp_n, accepts, exp_acc;
    bit exp_to, exp_err, bus_ok;
    logic [7:0] exp_rd, exp_pwd;
    n = 0;
    @(negedge pclk);
    while (!cmd_ready && n < 20) begin
      @(negedge pclk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait cmd_ready=%0b expected 1", cmd_ready);
      return;
    end
    if (prev_done) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rsp_pulse_width rsp_valid=%0b expected 0", rsp_valid);
      end
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    pready    = 1'b0;

    exp_to  = (waits >= TO);
    exp_acc = exp_to ? TO : waits + 1;
    exp_pwd = wr ? wd : 8'h00;
    if (exp_to) begin
      exp_err = 1'b1;
      exp_rd  = 8'h00;
    end else begin
      exp_err = serr;
      exp_rd  = (!wr && !serr) ? ref_mem[addr[3:0]] : 8'h00;
      if (wr && !serr) ref_mem[addr[3:0]] = wd;
    end

    rsp_n = -1; psel_cnt = 0; pen_cnt = 0; accepts = 0; acc_seen = 0; bus_ok = 1'b1;
    for (int c = 1; c <= 40 && rsp_n < 0; c++) begin
      @(negedge pclk);
      if (!hold) cmd_valid = 1'b0;
      if (cmd_valid && cmd_ready) accepts++;
      if (psel) begin
        psel_cnt++;
        if (paddr !== addr || pwrite !== wr || pwdata !== exp_pwd) bus_ok = 1'b0;
      end
      if (penable) pen_cnt++;
      if (rsp_valid) rsp_n = c;
      if (psel && penable) begin
        if (acc_seen < waits) begin
          pready  = 1'b0;
          pslverr = 1'($urandom);
          prdata  = 8'($urandom);
        end else begin
          pready  = 1'b1;
          pslverr = serr;
          prdata  = slave_mem[paddr[3:0]];
          if (pwrite && !serr) slave_mem[paddr[3:0]] = pwdata;
        end
        acc_seen++;
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = 8'($urandom);
      end
    end

    checks++;
    if (rsp_n !== exp_acc + 2) begin
      errors++;
      $display("FAIL rsp_latency got cycle %0d expected %0d", rsp_n, exp_acc + 2);
    end
    checks++;
    if (psel_cnt !== exp_acc + 1 || pen_cnt !== exp_acc) begin
      errors++;
      $display("FAIL psel_penable_cycles psel=%0d penable=%0d expected %0d/%0d",
               psel_cnt, pen_cnt, exp_acc + 1, exp_acc);
    end
    checks++;
    if (!bus_ok) begin
      errors++;
      $display("FAIL bus_stable paddr=%h pwrite=%0b pwdata=%h expected %h/%0b/%h",
               paddr, pwrite, pwdata, addr, wr, exp_pwd);
    end
    checks++;
    if (accepts !== 0) begin
      errors++;
      $display("FAIL extra_accept got %0d expected 0", accepts);
    end
    checks++;
    if (rsp_err !== exp_err || rsp_timeout !== exp_to || rsp_rdata !== exp_rd) begin
      errors++;
      $display("FAIL rsp_fields err=%0b to=%0b rdata=%h expected %0b/%0b/%h",
               rsp_err, rsp_timeout, rsp_rdata, exp_err, exp_to, exp_rd);
    end
    prev_done = 1'b1;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite} !== 7'b0 ||
        rsp_rdata !== 8'h00 || paddr !== 32'h0 || pwdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs ready=%0b valid=%0b psel=%0b pen=%0b paddr=%h expected all 0",
               cmd_ready, rsp_valid, psel, penable, paddr);
    end
    presetn = 1'b1;
    @(negedge pclk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset cmd_ready=%0b expected 1", cmd_ready);
    end
    prev_done = 1'b0;
  endtask

  task automatic test_write_basic();
    xfer(1'b1, 32'h5, 8'hA5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_read_wait();
    xfer(1'b0, 32'h3, 8'hFF, 3, 1'b0, 1'b0);
  endtask

  task automatic test_read_error();
    xfer(1'b0, 32'h14, 8'h00, 0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    xfer(1'b1, 32'h9, 8'h66, TO, 1'b0, 1'b0);
    xfer(1'b0, 32'h9, 8'h00, TO - 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit saw_rsp;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hB; cmd_wdata = 8'h11; pready = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drop psel=%0b penable=%0b rsp_valid=%0b expected 0",
               psel, penable, rsp_valid);
    end
    @(negedge pclk);
    presetn = 1'b1;
    saw_rsp = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_recover rsp_seen=%0b cmd_ready=%0b expected 0/1", saw_rsp, cmd_ready);
    end
    prev_done = 1'b0;
    xfer(1'b0, 32'h5, 8'h00, 1, 1'b0, 1'b0);
  endtask

  task automatic test_loopback();
    xfer(1'b1, 32'h7, 8'h5A, 0, 1'b0, 1'b1);
    xfer(1'b0, 32'h7, 8'h00, 0, 1'b0, 1'b1);
    cmd_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom), {28'($urandom_range(0, 3)), 4'($urandom)}, 8'($urandom),
           int'($urandom_range(0, TO + 1)), ($urandom_range(0, 4) == 0), 1'($urandom));
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i]   = slave_mem[i];
    end
    slave_mem[3] = 8'h3C;
    ref_mem[3]   = 8'h3C;
    test_reset();
    test_write_basic();
    test_read_wait();
    test_read_error();
    test_timeout();
    test_reset_mid();
    test_loopback();
    test_random();
    repeat (2) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
